// File: rtl/inst_mem_loader.sv
// Program loader: turns a framed byte stream (count, 3-byte words, XOR checksum) into
// single-cycle instruction memory writes at incrementing addresses.
module inst_mem_loader #(
  parameter int unsigned INSTRUCTION_MEM_SIZE   = 8192,
  parameter int unsigned INSTRUCTION_WIDTH      = 18,
  parameter int unsigned INSTRUCTION_ADDR_WIDTH = $clog2(INSTRUCTION_MEM_SIZE)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [7:0]                        i_byte,
  input  logic                              i_byte_valid,
  output logic                              o_byte_ready,
  output logic                              o_we,
  output logic [INSTRUCTION_ADDR_WIDTH-1:0] o_waddr,
  output logic [INSTRUCTION_WIDTH-1:0]      o_wdata,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_error,
  output logic [INSTRUCTION_ADDR_WIDTH:0]   o_words_written
);

  localparam int unsigned PadBits = 24 - INSTRUCTION_WIDTH;
  localparam int unsigned TopBits = INSTRUCTION_WIDTH - 16;
  // Bits of the first word byte that lie above the instruction width.
  localparam logic [7:0]  PadMask = 8'(~(8'hFF >> PadBits));

  typedef enum logic [3:0] {
    StIdle, StCntHi, StCntLo, StB0, StB1, StB2, StChk, StDone, StErr
  } state_e;

  state_e                            state_q;
  logic [7:0]                        chk_q;
  logic [7:0]                        cnt_hi_q;
  logic [15:0]                       count_q;
  logic [INSTRUCTION_ADDR_WIDTH-1:0] widx_q;
  logic [TopBits-1:0]                b0_q;
  logic [7:0]                        b1_q;

  logic        accept;
  logic [15:0] cnt_full;
  logic [15:0] words_next;

  assign o_byte_ready = state_q inside {StCntHi, StCntLo, StB0, StB1, StB2, StChk};
  assign o_busy       = o_byte_ready;
  assign accept       = i_byte_valid && o_byte_ready;
  assign cnt_full     = {cnt_hi_q, i_byte};
  assign words_next   = 16'(o_words_written) + 16'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= StIdle;
      chk_q           <= '0;
      cnt_hi_q        <= '0;
      count_q         <= '0;
      widx_q          <= '0;
      b0_q            <= '0;
      b1_q            <= '0;
      o_we            <= 1'b0;
      o_waddr         <= '0;
      o_wdata         <= '0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
      o_words_written <= '0;
    end else begin
      o_we <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          if (i_start) begin
            state_q         <= StCntHi;
            chk_q           <= '0;
            widx_q          <= '0;
            o_words_written <= '0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
          end
        end
        StCntHi: begin
          if (accept) begin
            cnt_hi_q <= i_byte;
            chk_q    <= chk_q ^ i_byte;
            state_q  <= StCntLo;
          end
        end
        StCntLo: begin
          if (accept) begin
            chk_q   <= chk_q ^ i_byte;
            count_q <= cnt_full;
            if (32'(cnt_full) > INSTRUCTION_MEM_SIZE) begin
              state_q <= StErr;
              o_error <= 1'b1;
            end else if (cnt_full == 16'd0) begin
              state_q <= StChk;
            end else begin
              state_q <= StB0;
            end
          end
        end
        StB0: begin
          if (accept) begin
            if (|(i_byte & PadMask)) begin
              state_q <= StErr;
              o_error <= 1'b1;
            end else begin
              b0_q    <= i_byte[TopBits-1:0];
              chk_q   <= chk_q ^ i_byte;
              state_q <= StB1;
            end
          end
        end
        StB1: begin
          if (accept) begin
            b1_q    <= i_byte;
            chk_q   <= chk_q ^ i_byte;
            state_q <= StB2;
          end
        end
        StB2: begin
          if (accept) begin
            chk_q           <= chk_q ^ i_byte;
            o_we            <= 1'b1;
            o_waddr         <= widx_q;
            o_wdata         <= {b0_q, b1_q, i_byte};
            widx_q          <= widx_q + INSTRUCTION_ADDR_WIDTH'(1);
            o_words_written <= o_words_written + (INSTRUCTION_ADDR_WIDTH + 1)'(1);
            state_q         <= (words_next < count_q) ? StB0 : StChk;
          end
        end
        StChk: begin
          if (accept) begin
            if (i_byte == chk_q) begin
              state_q <= StDone;
              o_done  <= 1'b1;
            end else begin
              state_q <= StErr;
              o_error <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: directed frames, writes checked through an expected-write queue.
module tb_inst_mem_loader;

  typedef struct {
    logic [12:0] addr;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  logic        r_clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_we;
  logic [12:0] o_waddr;
  logic [17:0] o_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [13:0] o_words_written;

  int         checks = 0;
  int         errors = 0;
  int         nwr = 0;
  int         cyc = 0;
  exp_t       q[$];
  logic [7:0] run_chk;

  inst_mem_loader dut (
    .i_clk          (r_clk),
    .i_rst          (rst),
    .i_start        (i_start),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_we           (o_we),
    .o_waddr        (o_waddr),
    .o_wdata        (o_wdata),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_written(o_words_written)
  );

  always #5 r_clk = ~r_clk;
  always @(posedge r_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write, including its cycle.
  always @(negedge r_clk) begin
    if (o_we === 1'b1) begin
      exp_t e;
      nwr++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                 o_waddr, o_wdata);
      end else begin
        e = q.pop_front();
        check("waddr", 32'(o_waddr), 32'(e.addr));
        check("wdata", 32'(o_wdata), 32'(e.data));
        check("write_cycle", cyc, e.cyc);
      end
    end
  end

  // Present one byte and hold it until accepted; called at #1 after a rising edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    forever begin
      @(negedge r_clk);
      if (o_byte_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL byte_ready_timeout: got ready=0, expected ready=1");
        break;
      end
    end
    @(posedge r_clk);
    #1;
    i_byte_valid = 1'b0;
    run_chk      = run_chk ^ b;
  endtask

  task automatic idle_maybe(input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [12:0] a, input logic [17:0] d, input bit gaps);
    exp_t e;
    idle_maybe(gaps);
    send({6'b0, d[17:16]});
    idle_maybe(gaps);
    send(d[15:8]);
    idle_maybe(gaps);
    send(d[7:0]);
    e.addr = a;
    e.data = d;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic start();
    i_start = 1'b1;
    @(posedge r_clk);
    #1;
    i_start = 1'b0;
    run_chk = 8'h00;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    rst          = 1'b1;
    i_start      = 1'b0;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    run_chk      = 8'h00;
    #12;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_ready", 32'(o_byte_ready), 0);
    check("rst_we", 32'(o_we), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_error", 32'(o_error), 0);
    check("rst_words", 32'(o_words_written), 0);
    @(posedge r_clk);
    #1;
    rst = 1'b0;
    @(posedge r_clk);
    #1;

    // Two-word frame with good checksum.
    start();
    check("start_busy", 32'(o_busy), 1);
    send(8'h00); send(8'h02);
    send_word(13'd0, 18'h3FFFF, 1'b0);
    send_word(13'd1, 18'h00001, 1'b0);
    send(8'h00);
    check("t1_done", 32'(o_done), 1);
    check("t1_error", 32'(o_error), 0);
    check("t1_words", 32'(o_words_written), 2);
    check("t1_busy", 32'(o_busy), 0);

    // Same frame, bad checksum.
    start();
    check("t2_cleared_done", 32'(o_done), 0);
    send(8'h00); send(8'h02);
    send_word(13'd0, 18'h3FFFF, 1'b0);
    send_word(13'd1, 18'h00001, 1'b0);
    send(8'h5A);
    check("t2_error", 32'(o_error), 1);
    check("t2_done", 32'(o_done), 0);
    check("t2_words", 32'(o_words_written), 2);

    // Oversize count.
    start();
    send(8'h20); send(8'h01);
    check("t3_error", 32'(o_error), 1);
    check("t3_ready", 32'(o_byte_ready), 0);
    check("t3_words", 32'(o_words_written), 0);

    // Zero count.
    start();
    send(8'h00); send(8'h00); send(8'h00);
    check("t4_done", 32'(o_done), 1);
    check("t4_error", 32'(o_error), 0);
    check("t4_words", 32'(o_words_written), 0);

    // Illegal pad bit in the first word byte.
    start();
    send(8'h00); send(8'h01); send(8'h04);
    check("t5_error", 32'(o_error), 1);
    check("t5_ready", 32'(o_byte_ready), 0);
    check("t5_words", 32'(o_words_written), 0);
    repeat (3) @(posedge r_clk);
    #1;

    // Full-size load at full rate, data = address, stray starts mid-load.
    start();
    send(8'h20); send(8'h00);
    for (int i = 0; i < 8192; i++) begin
      i_start = (i % 2000 == 1000);
      send_word(13'(i), 18'(i), 1'b0);
      i_start = 1'b0;
    end
    send(run_chk);
    check("t6_done", 32'(o_done), 1);
    check("t6_error", 32'(o_error), 0);
    check("t6_words", 32'(o_words_written), 8192);
    check("t6_last_addr", 32'(o_waddr), 32'h1FFF);
    check("t6_last_data", 32'(o_wdata), 32'h01FFF);

    // Shorter load with random valid gaps.
    start();
    send(8'h01); send(8'h2C);
    for (int i = 0; i < 300; i++) send_word(13'(i), 18'(i), 1'b1);
    send(run_chk);
    check("t7_done", 32'(o_done), 1);
    check("t7_words", 32'(o_words_written), 300);

    // Reset between B1 and B2 of word 5.
    start();
    wr0 = nwr;
    send(8'h00); send(8'h10);
    for (int i = 0; i < 5; i++) send_word(13'(i), 18'(i + 7), 1'b0);
    send(8'h00); send(8'h00);
    #2;
    rst = 1'b1;
    #1;
    check("t8_busy", 32'(o_busy), 0);
    check("t8_ready", 32'(o_byte_ready), 0);
    check("t8_we", 32'(o_we), 0);
    check("t8_words", 32'(o_words_written), 0);
    check("t8_waddr", 32'(o_waddr), 0);
    check("t8_wdata", 32'(o_wdata), 0);
    check("t8_done", 32'(o_done), 0);
    check("t8_writes_issued", nwr - wr0, 5);
    @(posedge r_clk);
    #1;
    rst = 1'b0;
    @(posedge r_clk);
    #1;
    start();
    send(8'h00); send(8'h02);
    send_word(13'd0, 18'h12345, 1'b0);
    send_word(13'd1, 18'h2A5A5, 1'b0);
    send(8'h67);
    check("t8_fresh_done", 32'(o_done), 1);
    check("t8_fresh_words", 32'(o_words_written), 2);

    repeat (3) @(posedge r_clk);
    #1;
    check("pending_writes", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Program loader, the write side of the instruction memory. It consumes a framed byte stream, assembles 18-bit instructions, and issues single-cycle write strobes with an incrementing address into the instruction memory's write port. It sits between the host link (UART/debug byte source) and inst_mem, and holds the core off via o_busy while a load is in progress. The frame is a 2-byte word count, then N instructions of 3 bytes each, then a 1-byte XOR checksum.

Parameters:
INSTRUCTION_MEM_SIZE, 8192, number of instruction words; also the maximum legal count.
INSTRUCTION_WIDTH, 18, instruction width in bits; legal range 17..24 (exactly 3 bytes per word).
INSTRUCTION_ADDR_WIDTH, $clog2(INSTRUCTION_MEM_SIZE), write address width (13 by default).

Ports:
i_clk  input  1  system clock; all state updates on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_start  input  1  one-cycle pulse that arms a load; honoured only in IDLE/DONE/ERR.
i_byte  input  8  stream byte.
i_byte_valid  input  1  i_byte is valid this cycle.
o_byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when valid && ready.
o_we  output  1  instruction memory write strobe, one cycle per word.
o_waddr  output  INSTRUCTION_ADDR_WIDTH  write address.
o_wdata  output  INSTRUCTION_WIDTH  write data.
o_busy  output  1  load in progress; the core must stall.
o_done  output  1  level: last load completed with a good checksum.
o_error  output  1  level: last load aborted.
o_words_written  output  INSTRUCTION_ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (async assert): state IDLE; every output is 0; the internal checksum, count and address registers are 0. Memory contents are not touched. This applies equally when reset lands mid-load: a partial image stays in memory, and o_done stays 0.
- States: IDLE, CNT_HI, CNT_LO, B0, B1, B2, CHK, DONE, ERR.
- o_byte_ready=1 only in CNT_HI, CNT_LO, B0, B1, B2 and CHK. o_busy=1 in those same states.
- i_start in IDLE/DONE/ERR:
  - next state CNT_HI;
  - clear checksum, word index, o_words_written, o_done and o_error.
  - i_start is ignored while busy.
- Every accepted byte from CNT_HI through B2 is XORed into the running checksum.
- CNT_HI: accept the high byte of the count. CNT_LO: accept the low byte; count = {hi,lo}. On that CNT_LO accept:
  - count > INSTRUCTION_MEM_SIZE -> ERR;
  - count == 0 -> CHK;
  - otherwise -> B0.
- B0 carries instruction bits [23:16]. Bits that fall above INSTRUCTION_WIDTH-1 (i_byte[7:2] by default) must be 0; otherwise -> ERR with no write for that word. B1 carries bits [15:8]; B2 carries bits [7:0].
- On the B2 accept, the registered outputs take effect the next cycle:
  - o_we=1 for exactly one cycle;
  - o_waddr = word index;
  - o_wdata = assembled word;
  - o_words_written increments in that same cycle.
- Write latency: 1 cycle from the B2 accept. o_waddr/o_wdata hold their last value while o_we=0.
- No backpressure during writes: o_byte_ready stays 1, so a byte accepted in the o_we cycle is processed normally. Full rate is 1 byte/cycle.
- After a B2 accept, the state goes to B0 if fewer than count words have been written, else to CHK. The word index increments modulo 2^INSTRUCTION_ADDR_WIDTH; count <= MEM_SIZE guarantees no wrap inside a legal load.
- CHK: compare the accepted byte with the running checksum.
  - Equal -> DONE: o_done=1, held until the next i_start.
  - Unequal -> ERR: o_error=1, held until the next i_start.
  - The checksum byte is not written.
- o_done and o_error are never 1 together. o_we is never 1 in IDLE/DONE/ERR, except for a final write that completes in the cycle the state enters CHK.
- i_byte_valid while not ready: the byte is ignored and not consumed.

Test Plan:
- Reset, then i_start; stream 00 02 | 03 FF FF | 00 00 01 | 00 -> o_we pulses with (addr 0, 0x3FFFF) and (addr 1, 0x00001), each 1 cycle after its third byte; o_done=1, o_error=0, o_words_written=2.
- Same frame with checksum 0x5A -> both words written, then o_error=1, o_done=0.
- Count 0x2001 (8193) -> ERR after the second byte, no o_we ever asserted; count 0x0000 with checksum 00 -> DONE, o_words_written=0.
- Frame 00 01 | 04 00 00 (illegal pad bit) -> ERR on the B0 accept, no write, o_byte_ready=0 afterwards.
- Full-rate load of 8192 words at 1 byte/cycle, data = address -> last write has addr 8191 and data 0x01FFF; every i_start during the load is ignored; random valid gaps give identical writes.
- i_rst asserted between the B1 and B2 bytes of word 5 -> outputs go to 0 immediately, 5 writes already issued; a following i_start runs a fresh, correct load.
